// File: rtl/fft_peak_detect.sv
// Purpose: streaming spectral peak finder; tracks the max-power bin (re^2+im^2) of one FFT frame.
// Latency: result valid 2 cycles after the final beat is accepted (input reg -> squares -> max update).
// Backpressure: ready_o high only while collecting; result held on peak_valid_o until peak_ready_i.
// Build option: define PEAK_SKIP_DC_EN to exclude bin 0 from the search (lowest eligible bin becomes 1).
module fft_peak_detect #(
    parameter int DATA_WIDTH    = 24,
    parameter int FFT_SIZE      = 256,
    parameter int ADDR_WIDTH    = 8,
    parameter int HALF_SPECTRUM = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic signed [DATA_WIDTH-1:0] data_real_i,
    input  logic signed [DATA_WIDTH-1:0] data_imag_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [ADDR_WIDTH-1:0]        peak_bin_o,
    output logic [2*DATA_WIDTH-1:0]      peak_power_o,
    output logic                         peak_valid_o,
    input  logic                         peak_ready_i
);

    localparam int PW = 2 * DATA_WIDTH;

`ifdef PEAK_SKIP_DC_EN
    localparam logic SKIP_DC = 1'b1;
`else
    localparam logic SKIP_DC = 1'b0;
`endif

    // Max registers restart from the lowest bin that can ever win.
    localparam logic [ADDR_WIDTH-1:0] INIT_BIN = SKIP_DC ? ADDR_WIDTH'(1) : '0;
    localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(FFT_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] HALF_BIN = ADDR_WIDTH'(FFT_SIZE / 2);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        RESULT  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   bin_cnt_q;
    logic                    drain_cnt_q;
    logic                    ready_q;
    logic                    peak_valid_q;

    logic                    beat_acc;
    logic                    take;
    logic                    bin_elig;

    // Stage 0: captured input beat
    logic                    in_vld_q;
    logic signed [DATA_WIDTH-1:0] in_re_q;
    logic signed [DATA_WIDTH-1:0] in_im_q;
    logic [ADDR_WIDTH-1:0]   in_bin_q;
    logic                    in_elig_q;

    // Stage 1: squared parts
    logic signed [PW-1:0]    re_ext;
    logic signed [PW-1:0]    im_ext;
    logic                    sq_vld_q;
    logic signed [PW-1:0]    re_sq_q;
    logic signed [PW-1:0]    im_sq_q;
    logic [ADDR_WIDTH-1:0]   sq_bin_q;
    logic                    sq_elig_q;

    // Stage 2: running maximum
    logic [PW-1:0]           power_sum;
    logic [PW-1:0]           max_pow_q;
    logic [ADDR_WIDTH-1:0]   max_bin_q;

    assign beat_acc = valid_i & ready_q;
    assign take     = peak_valid_q & peak_ready_i;

    // A bin competes only if it lies in the searched half and is not a skipped DC bin.
    assign bin_elig = ((HALF_SPECTRUM == 0) || (bin_cnt_q < HALF_BIN)) &&
                      !(SKIP_DC && (bin_cnt_q == '0));

    // Frame control: count accepted bins, drain the pipeline, then hold the result until taken.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= COLLECT;
            bin_cnt_q    <= '0;
            drain_cnt_q  <= 1'b0;
            ready_q      <= 1'b1;
            peak_valid_q <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (beat_acc) begin
                        if (bin_cnt_q == LAST_BIN) begin
                            bin_cnt_q   <= '0;
                            drain_cnt_q <= 1'b0;
                            ready_q     <= 1'b0;
                            state_q     <= DRAIN;
                        end else begin
                            bin_cnt_q <= bin_cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q) begin
                        peak_valid_q <= 1'b1;
                        state_q      <= RESULT;
                    end else begin
                        drain_cnt_q <= 1'b1;
                    end
                end
                RESULT: begin
                    if (peak_ready_i) begin
                        peak_valid_q <= 1'b0;
                        ready_q      <= 1'b1;
                        state_q      <= COLLECT;
                    end
                end
                default: begin
                    state_q      <= COLLECT;
                    bin_cnt_q    <= '0;
                    drain_cnt_q  <= 1'b0;
                    ready_q      <= 1'b1;
                    peak_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Stage 0 valid: one pulse per accepted beat; cleared by reset so partial frames vanish.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            in_vld_q <= 1'b0;
        end else begin
            in_vld_q <= beat_acc;
        end
    end

    // Stage 0 payload: sample, bin index and eligibility of the accepted beat.
    always_ff @(posedge clk_i) begin
        if (beat_acc) begin
            in_re_q   <= data_real_i;
            in_im_q   <= data_imag_i;
            in_bin_q  <= bin_cnt_q;
            in_elig_q <= bin_elig;
        end
    end

    // Sign-extend before multiplying so the full-width product is exact.
    assign re_ext = PW'(in_re_q);
    assign im_ext = PW'(in_im_q);

    // Stage 1 valid follows stage 0.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sq_vld_q <= 1'b0;
        end else begin
            sq_vld_q <= in_vld_q;
        end
    end

    // Stage 1 payload: squares of both parts; each is non-negative and at most 2^(PW-2).
    always_ff @(posedge clk_i) begin
        if (in_vld_q) begin
            re_sq_q   <= re_ext * re_ext;
            im_sq_q   <= im_ext * im_ext;
            sq_bin_q  <= in_bin_q;
            sq_elig_q <= in_elig_q;
        end
    end

    // Sum peaks at 2^(PW-1) with both parts at full negative scale, so PW bits never overflow.
    assign power_sum = $unsigned(re_sq_q) + $unsigned(im_sq_q);

    // Stage 2: strict greater-than keeps the lowest index on ties; restart on reset or result take.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || take) begin
            max_pow_q <= '0;
            max_bin_q <= INIT_BIN;
        end else if (sq_vld_q && sq_elig_q && (power_sum > max_pow_q)) begin
            max_pow_q <= power_sum;
            max_bin_q <= sq_bin_q;
        end
    end

    assign ready_o      = ready_q;
    assign peak_valid_o = peak_valid_q;
    assign peak_bin_o   = max_bin_q;
    assign peak_power_o = max_pow_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Bench for fft_peak_detect: directed frames against a frame-level peak model,
// two instances (half spectrum and full spectrum) fed the same stream.
// Honours PEAK_SKIP_DC_EN for the DC-dependent expectations.
module tb_fft_peak_detect;

    localparam int DW = 24;
    localparam int N  = 256;
    localparam int AW = 8;
    localparam int PW = 2 * DW;

`ifdef PEAK_SKIP_DC_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int INIT_BIN = SKIP ? 1 : 0;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic signed [DW-1:0] data_real_i = '0;
    logic signed [DW-1:0] data_imag_i = '0;
    logic                 valid_i = 1'b0;
    logic                 peak_ready_i = 1'b0;

    logic                 ready_o, peak_valid_o;
    logic [AW-1:0]        peak_bin_o;
    logic [PW-1:0]        peak_power_o;
    logic                 ready_f, valid_f;
    logic [AW-1:0]        bin_f;
    logic [PW-1:0]        pow_f;

    always #5 clk_i = ~clk_i;

    fft_peak_detect #(.DATA_WIDTH(DW), .FFT_SIZE(N), .ADDR_WIDTH(AW), .HALF_SPECTRUM(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_real_i(data_real_i), .data_imag_i(data_imag_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .peak_bin_o(peak_bin_o), .peak_power_o(peak_power_o),
        .peak_valid_o(peak_valid_o), .peak_ready_i(peak_ready_i)
    );

    fft_peak_detect #(.DATA_WIDTH(DW), .FFT_SIZE(N), .ADDR_WIDTH(AW), .HALF_SPECTRUM(0)) dut_f (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_real_i(data_real_i), .data_imag_i(data_imag_i),
        .valid_i(valid_i), .ready_o(ready_f),
        .peak_bin_o(bin_f), .peak_power_o(pow_f),
        .peak_valid_o(valid_f), .peak_ready_i(peak_ready_i)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    longint m_re[N];
    longint m_im[N];
    int     m_cnt     = 0;
    bit     exp_ready = 1'b1;
    bit     exp_valid = 1'b0;
    int     drain     = 0;
    bit     live      = 1'b0;
    int     eb_h = 0, eb_f = 0;
    longint ep_h = 0, ep_f = 0;

    // Strongest eligible bin of the stored frame; strict > keeps the lowest index on ties.
    function automatic void calc(input bit half, output int b, output longint p);
        p = 0;
        b = INIT_BIN;
        for (int i = 0; i < N; i++) begin
            longint pw;
            pw = m_re[i] * m_re[i] + m_im[i] * m_im[i];
            if ((!half || i < N / 2) && !(SKIP && i == 0) && pw > p) begin
                p = pw;
                b = i;
            end
        end
    endfunction

    // Compare process: check outputs against the model, then advance the model across the next edge.
    always @(negedge clk_i) begin
        if (live) begin
            check("ready", ready_o, exp_ready);
            check("valid", peak_valid_o, exp_valid);
            check("ready_full", ready_f, exp_ready);
            check("valid_full", valid_f, exp_valid);
            if (exp_valid) begin
                check("peak_bin", peak_bin_o, eb_h);
                check("peak_power", peak_power_o, ep_h);
                check("peak_bin_full", bin_f, eb_f);
                check("peak_power_full", pow_f, ep_f);
            end
        end
        if (!rst_ni) begin
            live      = 1'b1;
            m_cnt     = 0;
            exp_ready = 1'b1;
            exp_valid = 1'b0;
            drain     = 0;
        end else if (live) begin
            if (exp_ready && valid_i) begin
                m_re[m_cnt] = longint'(data_real_i);
                m_im[m_cnt] = longint'(data_imag_i);
                m_cnt++;
                if (m_cnt == N) begin
                    calc(1'b1, eb_h, ep_h);
                    calc(1'b0, eb_f, ep_f);
                    m_cnt     = 0;
                    exp_ready = 1'b0;
                    drain     = 2;
                end
            end else if (drain > 0) begin
                drain--;
                if (drain == 0) exp_valid = 1'b1;
            end else if (exp_valid && peak_ready_i) begin
                exp_valid = 1'b0;
                exp_ready = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic signed [DW-1:0] fr_re[N];
    logic signed [DW-1:0] fr_im[N];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_frame();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = '0;
            fr_im[i] = '0;
        end
    endtask

    task automatic drive_beat(input int b);
        bit acc;
        int guard;
        valid_i     = 1'b1;
        data_real_i = fr_re[b];
        data_imag_i = fr_im[b];
        guard = 0;
        do begin
            @(negedge clk_i);
            acc = ready_o;
            step();
            guard++;
        end while (!acc && guard < 50);
        if (!acc) check("beat_accept_timeout", 0, 1);
        valid_i = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct, input int nbeats);
        step();
        for (int b = 0; b < nbeats; b++) begin
            int idle;
            idle = 0;
            while (gap_pct > 0 && $urandom_range(99) < gap_pct && idle < 8) begin
                valid_i     = 1'b0;
                data_real_i = DW'($urandom);
                data_imag_i = DW'($urandom);
                idle++;
                step();
            end
            drive_beat(b);
        end
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!peak_valid_o && n < 20);
        if (!peak_valid_o) check("result_timeout", 0, 1);
    endtask

    task automatic take_result();
        step();
        peak_ready_i = 1'b1;
        step();
        peak_ready_i = 1'b0;
    endtask

    task automatic check_result(input string tag, input int bh, input longint ph,
                                input int bf, input longint pf);
        check({tag, "_bin"}, peak_bin_o, bh);
        check({tag, "_power"}, peak_power_o, ph);
        check({tag, "_bin_full"}, bin_f, bf);
        check({tag, "_power_full"}, pow_f, pf);
        check({tag, "_model_bin"}, eb_h, bh);
        check({tag, "_model_power"}, ep_h, ph);
    endtask

    initial begin
        int n;
        int dc_bin;
        longint dc_pow;

        // Reset state
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_ready", ready_o, 1);
        check("rst_valid", peak_valid_o, 0);
        check("rst_bin", peak_bin_o, INIT_BIN);
        check("rst_power", peak_power_o, 0);

        // Impulse at bin 37; peak_ready_i high while collecting must be ignored
        clear_frame();
        fr_re[37] = 24'sd1000;
        peak_ready_i = 1'b1;
        send_frame(0, N);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!peak_valid_o && n < 20);
        check("impulse_latency", n, 3);
        check_result("impulse", 37, 1000000, 37, 1000000);
        step();
        peak_ready_i = 1'b0;
        @(negedge clk_i);
        check("impulse_taken_valid", peak_valid_o, 0);
        check("impulse_taken_ready", ready_o, 1);

        // Tie: lowest index wins
        clear_frame();
        fr_re[10] = 24'sd300;  fr_im[10] = -24'sd400;
        fr_re[20] = 24'sd300;  fr_im[20] = -24'sd400;
        send_frame(0, N);
        wait_result();
        check_result("tie", 10, 250000, 10, 250000);
        take_result();

        // Full negative scale on both parts
        clear_frame();
        fr_re[5] = -24'sd8388608;
        fr_im[5] = -24'sd8388608;
        send_frame(0, N);
        wait_result();
        check_result("fullscale", 5, 64'd140737488355328, 5, 64'd140737488355328);
        take_result();

        // Half spectrum vs full spectrum
        clear_frame();
        fr_re[200] = 24'sd20000;
        fr_re[3]   = 24'sd10;
        send_frame(0, N);
        wait_result();
        check_result("half", 3, 100, 200, 400000000);
        take_result();

        // Backpressure and DC handling
        clear_frame();
        fr_re[0] = 24'sd5000;
        fr_re[1] = 24'sd1;
        dc_bin = SKIP ? 1 : 0;
        dc_pow = SKIP ? 64'd1 : 64'd25000000;
        send_frame(50, N);
        valid_i     = 1'b1;
        data_real_i = 24'sd7777777;
        data_imag_i = 24'sd7777777;
        wait_result();
        check_result("dc", dc_bin, dc_pow, dc_bin, dc_pow);
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk_i);
            check("hold_valid", peak_valid_o, 1);
            check("hold_ready", ready_o, 0);
            check("hold_bin", peak_bin_o, dc_bin);
            check("hold_power", peak_power_o, dc_pow);
        end
        step();
        valid_i      = 1'b0;
        peak_ready_i = 1'b1;
        step();
        peak_ready_i = 1'b0;
        @(negedge clk_i);
        check("after_take_ready", ready_o, 1);
        check("after_take_valid", peak_valid_o, 0);

        // Reset mid-frame, then a clean impulse frame at bin 50
        clear_frame();
        fr_re[10] = 24'sd30000;
        fr_im[60] = 24'sd30000;
        send_frame(0, 100);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        clear_frame();
        fr_re[50] = 24'sd700;
        send_frame(0, N);
        wait_result();
        check_result("midreset", 50, 490000, 50, 490000);
        take_result();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check("no_second_result", peak_valid_o, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
